// File: rtl/colour_channel_regs.sv
// Button-driven colour register bank: debounced set/next buttons write a pending
// bank that commits to the DAC-facing bank immediately or on frame_start.
module colour_channel_regs #(
   parameter int NUM_CHANNELS    = 3,
   parameter int CHANNEL_WIDTH   = 8,
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter bit COMMIT_ON_FRAME = 1'b1,
   parameter logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0] RESET_VALUES = {8'hDE, 8'h00, 8'hFF}
) (
   input  logic                                    clk_ref,
   input  logic                                    rst,
   input  logic                                    btn_set_n,
   input  logic                                    btn_next_n,
   input  logic [CHANNEL_WIDTH-1:0]                value_in,
   input  logic                                    frame_start,
   output logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0]   channel_values,
   output logic [3:0]                              sel_channel,
   output logic [CHANNEL_WIDTH-1:0]                led_value,
   output logic [6:0]                              segment_leds,
   output logic                                    pending_flag
);

   localparam int BW = NUM_CHANNELS * CHANNEL_WIDTH;
   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   // Bit 0 is the set button, bit 1 the next button.
   logic [1:0]    btn_raw;
   logic [1:0]    sync1_q, sync2_q;
   logic [1:0]    deb_q, deb_d, deb_prev_q;
   logic [1:0]    evt_q;
   logic [CW-1:0] cnt_q [2];
   logic [CW-1:0] cnt_d [2];

   logic          set_evt, next_evt;
   logic [3:0]    sel_q, sel_d;
   logic [BW-1:0] pending_q, pending_d;
   logic [BW-1:0] committed_q, committed_d;
   logic [CHANNEL_WIDTH-1:0] led_q, led_d;
   logic [6:0]    segment_q;
   logic          pending_flag_q;

   assign btn_raw  = {btn_next_n, btn_set_n};
   assign set_evt  = evt_q[0];
   assign next_evt = evt_q[1];

   function automatic logic [6:0] hex_glyph(input logic [3:0] v);
      logic [6:0] g;
      case (v)
         4'h0: g = 7'h40;  4'h1: g = 7'h79;  4'h2: g = 7'h24;  4'h3: g = 7'h30;
         4'h4: g = 7'h19;  4'h5: g = 7'h12;  4'h6: g = 7'h02;  4'h7: g = 7'h78;
         4'h8: g = 7'h00;  4'h9: g = 7'h10;  4'hA: g = 7'h08;  4'hB: g = 7'h03;
         4'hC: g = 7'h46;  4'hD: g = 7'h21;  4'hE: g = 7'h06;  default: g = 7'h0E;
      endcase
      return g;
   endfunction

   // A level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
   always_comb begin
      deb_d = deb_q;
      for (int i = 0; i < 2; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != deb_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               deb_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_ref or posedge rst) begin
      if (rst) begin
         sync1_q    <= 2'b11;
         sync2_q    <= 2'b11;
         deb_q      <= 2'b11;
         deb_prev_q <= 2'b11;
         evt_q      <= 2'b00;
         cnt_q[0]   <= '0;
         cnt_q[1]   <= '0;
      end else begin
         sync1_q    <= btn_raw;
         sync2_q    <= sync1_q;
         deb_q      <= deb_d;
         deb_prev_q <= deb_q;
         evt_q      <= deb_prev_q & ~deb_q;
         cnt_q[0]   <= cnt_d[0];
         cnt_q[1]   <= cnt_d[1];
      end
   end

   // The write uses the pre-advance selection when both events coincide.
   always_comb begin
      pending_d = pending_q;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         if (set_evt && (sel_q == 4'(i))) begin
            pending_d[i*CHANNEL_WIDTH +: CHANNEL_WIDTH] = value_in;
         end
      end

      sel_d = sel_q;
      if (next_evt) begin
         sel_d = (sel_q == 4'(NUM_CHANNELS - 1)) ? 4'd0 : sel_q + 4'd1;
      end

      committed_d = committed_q;
      if (!COMMIT_ON_FRAME || frame_start) begin
         committed_d = pending_d;
      end

      led_d = '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         if (sel_q == 4'(i)) begin
            led_d = pending_q[i*CHANNEL_WIDTH +: CHANNEL_WIDTH];
         end
      end
   end

   always_ff @(posedge clk_ref or posedge rst) begin
      if (rst) begin
         pending_q      <= RESET_VALUES;
         committed_q    <= RESET_VALUES;
         sel_q          <= 4'd0;
         led_q          <= RESET_VALUES[CHANNEL_WIDTH-1:0];
         segment_q      <= 7'h40;
         pending_flag_q <= 1'b0;
      end else begin
         pending_q      <= pending_d;
         committed_q    <= committed_d;
         sel_q          <= sel_d;
         led_q          <= led_d;
         segment_q      <= hex_glyph(sel_q);
         pending_flag_q <= (pending_q != committed_q);
      end
   end

   assign channel_values = committed_q;
   assign sel_channel    = sel_q;
   assign led_value      = led_q;
   assign segment_leds   = segment_q;
   assign pending_flag   = pending_flag_q;

endmodule

// File: tb/tb_colour_channel_regs.sv
// Bench for colour_channel_regs: frame-commit and immediate-commit instances share
// stimulus; a bank-level model predicts outputs after each button action.
module tb_colour_channel_regs;

   localparam int DEB = 4;
   localparam int NCH = 3;
   localparam logic [23:0] RST_IMG = 24'hDE00FF;

   logic        clk_ref = 1'b0;
   logic        rst;
   logic        btn_set_n, btn_next_n, frame_start;
   logic [7:0]  value_in;

   logic [23:0] ch_f, ch_c;
   logic [3:0]  sel_f, sel_c;
   logic [7:0]  led_f, led_c;
   logic [6:0]  seg_f, seg_c;
   logic        flag_f, flag_c;

   int n_checks = 0;
   int n_errors = 0;

   // Behavioural model: pending/committed images and current selection.
   logic [23:0] m_pend, m_comm;
   int          m_sel;

   logic [6:0] glyph_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   always #5 clk_ref = ~clk_ref;

   colour_channel_regs #(
      .NUM_CHANNELS(NCH), .CHANNEL_WIDTH(8), .DEBOUNCE_CYCLES(DEB),
      .COMMIT_ON_FRAME(1'b1), .RESET_VALUES(RST_IMG)
   ) dut_f (
      .clk_ref(clk_ref), .rst(rst), .btn_set_n(btn_set_n), .btn_next_n(btn_next_n),
      .value_in(value_in), .frame_start(frame_start), .channel_values(ch_f),
      .sel_channel(sel_f), .led_value(led_f), .segment_leds(seg_f), .pending_flag(flag_f)
   );

   colour_channel_regs #(
      .NUM_CHANNELS(NCH), .CHANNEL_WIDTH(8), .DEBOUNCE_CYCLES(DEB),
      .COMMIT_ON_FRAME(1'b0), .RESET_VALUES(RST_IMG)
   ) dut_c (
      .clk_ref(clk_ref), .rst(rst), .btn_set_n(btn_set_n), .btn_next_n(btn_next_n),
      .value_in(value_in), .frame_start(frame_start), .channel_values(ch_c),
      .sel_channel(sel_c), .led_value(led_c), .segment_leds(seg_c), .pending_flag(flag_c)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk_ref);
   endtask

   task automatic model_reset();
      m_pend = RST_IMG;
      m_comm = RST_IMG;
      m_sel  = 0;
   endtask

   task automatic check_all(input string tag);
      check({tag, ".bank_f"}, 32'(ch_f), 32'(m_comm));
      check({tag, ".bank_c"}, 32'(ch_c), 32'(m_pend));
      check({tag, ".sel_f"},  32'(sel_f), 32'(m_sel));
      check({tag, ".sel_c"},  32'(sel_c), 32'(m_sel));
      check({tag, ".led_f"},  32'(led_f), 32'(m_pend[m_sel*8 +: 8]));
      check({tag, ".led_c"},  32'(led_c), 32'(m_pend[m_sel*8 +: 8]));
      check({tag, ".seg_f"},  32'(seg_f), 32'(glyph_tbl[m_sel]));
      check({tag, ".seg_c"},  32'(seg_c), 32'(glyph_tbl[m_sel]));
      check({tag, ".flag_f"}, 32'(flag_f), 32'(m_pend != m_comm));
      check({tag, ".flag_c"}, 32'(flag_c), 32'd0);
   endtask

   // Hold the chosen buttons low for len cycles, then release long enough to settle.
   task automatic press(input bit do_set, input bit do_next, input int len, input logic [7:0] val);
      value_in   = val;
      btn_set_n  = !do_set;
      btn_next_n = !do_next;
      tick(len);
      btn_set_n  = 1'b1;
      btn_next_n = 1'b1;
      tick(DEB + 6);
      if (len >= DEB) begin
         if (do_set)  m_pend[m_sel*8 +: 8] = val;
         if (do_next) m_sel = (m_sel == NCH - 1) ? 0 : m_sel + 1;
      end
   endtask

   task automatic frame_pulse();
      frame_start = 1'b1;
      tick(1);
      frame_start = 1'b0;
      m_comm = m_pend;
      tick(2);
   endtask

   initial begin
      rst = 1'b1; btn_set_n = 1'b1; btn_next_n = 1'b1; frame_start = 1'b0; value_in = 8'h00;
      model_reset();
      tick(3);
      rst = 1'b0;
      tick(2);
      check_all("reset");

      // Set press with exact timing: write lands at the 8th edge, LED one edge later.
      value_in = 8'h3C;
      btn_set_n = 1'b0;
      tick(7);
      check("t_set.c_before", 32'(ch_c[7:0]), 32'h00FF);
      tick(1);
      check("t_set.c_at", 32'(ch_c[7:0]), 32'h3C);
      check("t_set.led_before", 32'(led_f), 32'hFF);
      tick(1);
      check("t_set.led_at", 32'(led_f), 32'h3C);
      check("t_set.flag", 32'(flag_f), 32'd1);
      check("t_set.bank_hold", 32'(ch_f), 32'(RST_IMG));
      tick(1);
      btn_set_n = 1'b1;
      tick(DEB + 6);
      m_pend[7:0] = 8'h3C;
      check_all("t_set.held");
      frame_pulse();
      check_all("t_set.commit");

      // Short glitch on next is ignored; three full presses walk and wrap.
      press(1'b0, 1'b1, DEB - 1, 8'h00);
      check_all("glitch");
      for (int i = 0; i < 3; i++) begin
         press(1'b0, 1'b1, DEB + 2, 8'h00);
         check_all($sformatf("next%0d", i));
      end

      // Both buttons with sel=1 and a coincident frame_start.
      press(1'b0, 1'b1, DEB + 2, 8'h00);
      value_in = 8'hAA;
      btn_set_n = 1'b0;
      btn_next_n = 1'b0;
      tick(7);
      frame_start = 1'b1;
      tick(1);
      frame_start = 1'b0;
      check("both.bank_f", 32'(ch_f[15:8]), 32'hAA);
      check("both.sel_f", 32'(sel_f), 32'd2);
      tick(2);
      btn_set_n = 1'b1;
      btn_next_n = 1'b1;
      tick(DEB + 6);
      m_pend[15:8] = 8'hAA;
      m_sel = 2;
      m_comm = m_pend;
      check_all("both.settled");

      // Async reset while set is held mid-debounce; the press must re-qualify.
      value_in = 8'h77;
      btn_set_n = 1'b0;
      tick(2);
      @(posedge clk_ref);
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_all("rst_mid");
      @(negedge clk_ref);
      rst = 1'b0;
      tick(8);
      check("rst_mid.led_before", 32'(led_f), 32'hFF);
      tick(1);
      check("rst_mid.led_at", 32'(led_f), 32'h77);
      btn_set_n = 1'b1;
      tick(DEB + 6);
      m_pend[7:0] = 8'h77;
      check_all("rst_mid.settled");

      // Randomised button and frame activity.
      for (int i = 0; i < 40; i++) begin
         int kind;
         logic [7:0] v;
         kind = $urandom_range(0, 4);
         v = 8'($urandom_range(0, 255));
         case (kind)
            0: press(1'b1, 1'b0, $urandom_range(DEB, DEB + 5), v);
            1: press(1'b0, 1'b1, $urandom_range(DEB, DEB + 5), v);
            2: press(1'b1, 1'b1, $urandom_range(DEB, DEB + 5), v);
            3: press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     $urandom_range(1, DEB - 1), v);
            default: frame_pulse();
         endcase
         check_all($sformatf("rnd%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
